// File: rtl/instr_encoder.sv
// instr_encoder: turns a symbolic RV32IMA instruction (name enum, register
// fields, immediate, aq/rl) into its 32-bit machine word, through a single
// registered stage with valid/ready handshakes. Each emitted word carries the
// byte address it belongs at, and a count of words transferred is kept.
//
// Optional build macro: ENC_IMM_CHECK_EN. When it is defined, out_err also
// flags immediates that do not fit their format. The word is still emitted
// with the truncated fields.

package risc_v_core_pkg;

  // Instruction names, shared with the core's decoder
  typedef enum logic [5:0] {
    INVALID,
    NOP,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    LR_W, SC_W, AMOSWAP_W, AMOADD_W, AMOXOR_W, AMOAND_W, AMOOR_W,
    AMOMIN_W, AMOMAX_W, AMOMINU_W, AMOMAXU_W
  } instr_name_e;

endpackage

module instr_encoder
  import risc_v_core_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  instr_name_e       in_name,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic [1:0]        in_aqrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       word_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // Bit layout used to assemble the word; SHIFT is I-type with funct7 on top
  typedef enum logic [3:0] {
    FMT_BAD, FMT_NOP, FMT_R, FMT_I, FMT_SHIFT, FMT_S, FMT_B, FMT_U, FMT_J, FMT_AMO
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  f5;
  logic        is_lr;
  logic [4:0]  amo_rs2;
  logic [31:0] enc_word;
  logic        enc_bad;
  logic        range_err;
  logic        accept;
  logic        xfer;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Map each instruction name to its format, opcode and function fields
  always_comb begin
    fmt   = FMT_BAD;
    op    = 7'b0000000;
    f3    = 3'b000;
    f7    = F7_BASE;
    f5    = 5'b00000;
    is_lr = 1'b0;
    case (in_name)
      NOP:       fmt = FMT_NOP;
      LUI:       begin fmt = FMT_U; op = OP_LUI;   end
      AUIPC:     begin fmt = FMT_U; op = OP_AUIPC; end
      JAL:       begin fmt = FMT_J; op = OP_JAL;   end
      JALR:      begin fmt = FMT_I; op = OP_JALR; f3 = 3'b000; end
      BEQ:       begin fmt = FMT_B; op = OP_BRANCH; f3 = 3'b000; end
      BNE:       begin fmt = FMT_B; op = OP_BRANCH; f3 = 3'b001; end
      BLT:       begin fmt = FMT_B; op = OP_BRANCH; f3 = 3'b100; end
      BGE:       begin fmt = FMT_B; op = OP_BRANCH; f3 = 3'b101; end
      BLTU:      begin fmt = FMT_B; op = OP_BRANCH; f3 = 3'b110; end
      BGEU:      begin fmt = FMT_B; op = OP_BRANCH; f3 = 3'b111; end
      LB:        begin fmt = FMT_I; op = OP_LOAD; f3 = 3'b000; end
      LH:        begin fmt = FMT_I; op = OP_LOAD; f3 = 3'b001; end
      LW:        begin fmt = FMT_I; op = OP_LOAD; f3 = 3'b010; end
      LBU:       begin fmt = FMT_I; op = OP_LOAD; f3 = 3'b100; end
      LHU:       begin fmt = FMT_I; op = OP_LOAD; f3 = 3'b101; end
      SB:        begin fmt = FMT_S; op = OP_STORE; f3 = 3'b000; end
      SH:        begin fmt = FMT_S; op = OP_STORE; f3 = 3'b001; end
      SW:        begin fmt = FMT_S; op = OP_STORE; f3 = 3'b010; end
      ADDI:      begin fmt = FMT_I; op = OP_IMM; f3 = 3'b000; end
      SLTI:      begin fmt = FMT_I; op = OP_IMM; f3 = 3'b010; end
      SLTIU:     begin fmt = FMT_I; op = OP_IMM; f3 = 3'b011; end
      XORI:      begin fmt = FMT_I; op = OP_IMM; f3 = 3'b100; end
      ORI:       begin fmt = FMT_I; op = OP_IMM; f3 = 3'b110; end
      ANDI:      begin fmt = FMT_I; op = OP_IMM; f3 = 3'b111; end
      SLLI:      begin fmt = FMT_SHIFT; op = OP_IMM; f3 = 3'b001; end
      SRLI:      begin fmt = FMT_SHIFT; op = OP_IMM; f3 = 3'b101; end
      SRAI:      begin fmt = FMT_SHIFT; op = OP_IMM; f3 = 3'b101; f7 = F7_ALT; end
      ADD:       begin fmt = FMT_R; op = OP_R; f3 = 3'b000; end
      SUB:       begin fmt = FMT_R; op = OP_R; f3 = 3'b000; f7 = F7_ALT; end
      SLL:       begin fmt = FMT_R; op = OP_R; f3 = 3'b001; end
      SLT:       begin fmt = FMT_R; op = OP_R; f3 = 3'b010; end
      SLTU:      begin fmt = FMT_R; op = OP_R; f3 = 3'b011; end
      XOR:       begin fmt = FMT_R; op = OP_R; f3 = 3'b100; end
      SRL:       begin fmt = FMT_R; op = OP_R; f3 = 3'b101; end
      SRA:       begin fmt = FMT_R; op = OP_R; f3 = 3'b101; f7 = F7_ALT; end
      OR:        begin fmt = FMT_R; op = OP_R; f3 = 3'b110; end
      AND:       begin fmt = FMT_R; op = OP_R; f3 = 3'b111; end
      MUL:       begin fmt = FMT_R; op = OP_R; f3 = 3'b000; f7 = F7_MEXT; end
      MULH:      begin fmt = FMT_R; op = OP_R; f3 = 3'b001; f7 = F7_MEXT; end
      MULHSU:    begin fmt = FMT_R; op = OP_R; f3 = 3'b010; f7 = F7_MEXT; end
      MULHU:     begin fmt = FMT_R; op = OP_R; f3 = 3'b011; f7 = F7_MEXT; end
      DIV:       begin fmt = FMT_R; op = OP_R; f3 = 3'b100; f7 = F7_MEXT; end
      DIVU:      begin fmt = FMT_R; op = OP_R; f3 = 3'b101; f7 = F7_MEXT; end
      REM:       begin fmt = FMT_R; op = OP_R; f3 = 3'b110; f7 = F7_MEXT; end
      REMU:      begin fmt = FMT_R; op = OP_R; f3 = 3'b111; f7 = F7_MEXT; end
      LR_W:      begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b00010; is_lr = 1'b1; end
      SC_W:      begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b00011; end
      AMOSWAP_W: begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b00001; end
      AMOADD_W:  begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b00000; end
      AMOXOR_W:  begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b00100; end
      AMOOR_W:   begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b01000; end
      AMOAND_W:  begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b01100; end
      AMOMIN_W:  begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b10000; end
      AMOMAX_W:  begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b10100; end
      AMOMINU_W: begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b11000; end
      AMOMAXU_W: begin fmt = FMT_AMO; op = OP_AMO; f5 = 5'b11100; end
      default:   fmt = FMT_BAD;
    endcase
  end

  // LR.W has no data operand, so its rs2 slot is always zero
  assign amo_rs2 = is_lr ? 5'd0 : in_rs2;

  // Pack the fields into the machine word for the selected format
  always_comb begin
    enc_word = 32'h0000_0000;
    enc_bad  = 1'b0;
    case (fmt)
      FMT_NOP:   enc_word = 32'h0000_0013;
      FMT_R:     enc_word = {f7, in_rs2, in_rs1, f3, in_rd, op};
      FMT_I:     enc_word = {in_imm[11:0], in_rs1, f3, in_rd, op};
      FMT_SHIFT: enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, op};
      FMT_S:     enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], op};
      FMT_B:     enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                             in_imm[4:1], in_imm[11], op};
      FMT_U:     enc_word = {in_imm[31:12], in_rd, op};
      FMT_J:     enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, op};
      FMT_AMO:   enc_word = {f5, in_aqrl, amo_rs2, in_rs1, 3'b010, in_rd, op};
      default: begin
        enc_word = 32'h0000_0000;
        enc_bad  = 1'b1;
      end
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  // Flag immediates whose upper bits would be lost, or whose alignment is wrong
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = (in_imm[31:11] != {21{in_imm[11]}});
      FMT_SHIFT:    range_err = (in_imm[31:5] != 27'd0);
      FMT_B:        range_err = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
      FMT_J:        range_err = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
      FMT_U:        range_err = (in_imm[11:0] != 12'd0);
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  // Output stage: flush clears it, a transfer advances address and count,
  // and an accept reloads the word (same-cycle transfer+accept has no bubble)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_word   <= 32'h0000_0000;
      out_err    <= 1'b0;
      out_addr   <= BASE_ADDR;
      word_count <= 16'd0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_word   <= 32'h0000_0000;
      out_err    <= 1'b0;
      out_addr   <= BASE_ADDR;
      word_count <= 16'd0;
    end else begin
      if (xfer) begin
        out_addr <= out_addr + ADDR_W'(4);
        if (word_count != 16'hFFFF) begin
          word_count <= word_count + 16'd1;
        end
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_word  <= enc_word;
        out_err   <= enc_bad || range_err;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven check of the encoder's words and error flag,
// plus hand-written sequences for stall, flush, back-to-back and reset.
// Honours ENC_IMM_CHECK_EN for the out-of-range immediate vector.

module tb_instr_encoder;
  import risc_v_core_pkg::*;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;
`ifdef ENC_IMM_CHECK_EN
  localparam logic        IMM_CHK = 1'b1;
`else
  localparam logic        IMM_CHK = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  instr_name_e       in_name;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic [1:0]        in_aqrl;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [15:0]       word_count;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_name(in_name),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_aqrl(in_aqrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .out_err(out_err),
    .word_count(word_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  name;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [1:0]  aqrl;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  int n_checks;
  int n_fail;

  task automatic check_output(input string label, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", label, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    in_name  = instr_name_e'(v.name);
    in_rd    = v.rd;
    in_rs1   = v.rs1;
    in_rs2   = v.rs2;
    in_imm   = v.imm;
    in_aqrl  = v.aqrl;
    in_valid = 1'b1;
  endtask

  // Main sequence
  initial begin
    logic [5:0] bad_name;
    logic [31:0] held_word;
    bad_name = 6'd63;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{ADDI,      5'd1,  5'd0,  5'd0, 32'd5,          2'b00, 32'h00500093, 1'b0};
    vecs[1]  = '{ADD,       5'd3,  5'd1,  5'd2, 32'd0,          2'b00, 32'h002081B3, 1'b0};
    vecs[2]  = '{SUB,       5'd3,  5'd1,  5'd2, 32'd0,          2'b00, 32'h402081B3, 1'b0};
    vecs[3]  = '{MUL,       5'd3,  5'd1,  5'd2, 32'd0,          2'b00, 32'h022081B3, 1'b0};
    vecs[4]  = '{SW,        5'd0,  5'd1,  5'd2, 32'd8,          2'b00, 32'h0020A423, 1'b0};
    vecs[5]  = '{BEQ,       5'd0,  5'd0,  5'd0, 32'hFFFF_FFFC,  2'b00, 32'hFE000EE3, 1'b0};
    vecs[6]  = '{LUI,       5'd5,  5'd0,  5'd0, 32'h1234_5000,  2'b00, 32'h123452B7, 1'b0};
    vecs[7]  = '{AMOADD_W,  5'd3,  5'd1,  5'd2, 32'd0,          2'b00, 32'h0020A1AF, 1'b0};
    vecs[8]  = '{INVALID,   5'd3,  5'd1,  5'd2, 32'd7,          2'b00, 32'h00000000, 1'b1};
    vecs[9]  = '{JAL,       5'd1,  5'd0,  5'd0, 32'd8,          2'b00, 32'h008000EF, 1'b0};
    vecs[10] = '{JAL,       5'd0,  5'd0,  5'd0, 32'hFFFF_FFF8,  2'b00, 32'hFF9FF06F, 1'b0};
    vecs[11] = '{AUIPC,     5'd2,  5'd0,  5'd0, 32'hFFFF_F000,  2'b00, 32'hFFFFF117, 1'b0};
    vecs[12] = '{SRAI,      5'd5,  5'd6,  5'd0, 32'd3,          2'b00, 32'h40335293, 1'b0};
    vecs[13] = '{SLLI,      5'd1,  5'd1,  5'd0, 32'd31,         2'b00, 32'h01F09093, 1'b0};
    vecs[14] = '{LR_W,      5'd5,  5'd10, 5'd7, 32'd0,          2'b10, 32'h140522AF, 1'b0};
    vecs[15] = '{SC_W,      5'd3,  5'd1,  5'd2, 32'd0,          2'b01, 32'h1A20A1AF, 1'b0};
    vecs[16] = '{AMOMAXU_W, 5'd3,  5'd1,  5'd2, 32'd0,          2'b11, 32'hE620A1AF, 1'b0};
    vecs[17] = '{NOP,       5'd7,  5'd7,  5'd7, 32'd123,        2'b11, 32'h00000013, 1'b0};
    vecs[18] = '{LW,        5'd10, 5'd2,  5'd0, 32'hFFFF_FFFC,  2'b00, 32'hFFC12503, 1'b0};
    vecs[19] = '{BNE,       5'd0,  5'd5,  5'd6, 32'd16,         2'b00, 32'h00629863, 1'b0};
    vecs[20] = '{JALR,      5'd0,  5'd1,  5'd0, 32'd0,          2'b00, 32'h00008067, 1'b0};
    vecs[21] = '{SRA,       5'd3,  5'd1,  5'd2, 32'd0,          2'b00, 32'h4020D1B3, 1'b0};
    vecs[22] = '{REMU,      5'd3,  5'd1,  5'd2, 32'd0,          2'b00, 32'h0220F1B3, 1'b0};
    vecs[23] = '{SB,        5'd0,  5'd2,  5'd5, 32'hFFFF_FFFF,  2'b00, 32'hFE510FA3, 1'b0};
    vecs[24] = '{XORI,      5'd4,  5'd4,  5'd0, 32'hFFFF_FFFF,  2'b00, 32'hFFF24213, 1'b0};
    vecs[25] = '{bad_name,  5'd1,  5'd1,  5'd1, 32'd1,          2'b00, 32'h00000000, 1'b1};
    vecs[26] = '{ADDI,      5'd1,  5'd0,  5'd0, 32'd4096,       2'b00, 32'h00000093, IMM_CHK};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_name = NOP; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_imm = 32'd0; in_aqrl = 2'b00;

    #1;
    check_output("reset out_valid",  32'(out_valid),  32'd0);
    check_output("reset out_word",   out_word,        32'd0);
    check_output("reset out_err",    32'(out_err),    32'd0);
    check_output("reset out_addr",   out_addr,        BASE);
    check_output("reset word_count", 32'(word_count), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("in_ready after reset", 32'(in_ready), 32'd1);

    // Streamed vectors: one word per cycle, each transferring on the next edge
    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i]);
      @(posedge clk); #1;
      check_output($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check_output($sformatf("vec%0d out_word", i), out_word, vecs[i].exp_word);
      check_output($sformatf("vec%0d out_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      check_output($sformatf("vec%0d out_addr", i), out_addr, BASE + 32'(4 * i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_output("drain out_valid",  32'(out_valid),  32'd0);
    check_output("drain word_count", 32'(word_count), 32'(NV));
    check_output("drain out_addr",   out_addr,        BASE + 32'(4 * NV));

    // Stall: consumer not ready for three cycles while a new request waits
    out_ready = 1'b0;
    apply_stimulus(vecs[0]);
    @(posedge clk); #1;
    held_word = 32'h00500093;
    check_output("stall load word", out_word, held_word);
    apply_stimulus(vecs[1]);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_output($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
      check_output($sformatf("stall%0d out_valid", c), 32'(out_valid), 32'd1);
      check_output($sformatf("stall%0d out_word", c), out_word, held_word);
      check_output($sformatf("stall%0d out_addr", c), out_addr, BASE + 32'(4 * NV));
      check_output($sformatf("stall%0d word_count", c), 32'(word_count), 32'(NV));
    end

    // Flush mid-stall drops the held word and the waiting request
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_output("flush out_valid",  32'(out_valid),  32'd0);
    check_output("flush out_addr",   out_addr,        BASE);
    check_output("flush word_count", 32'(word_count), 32'd0);
    @(posedge clk); #1;
    check_output("post-flush out_valid", 32'(out_valid), 32'd0);

    // Back-to-back ADD / SUB / MUL with the consumer always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(vecs[i]);
      @(posedge clk); #1;
      check_output($sformatf("b2b%0d out_valid", i), 32'(out_valid), 32'd1);
      check_output($sformatf("b2b%0d out_word", i), out_word, vecs[i].exp_word);
      check_output($sformatf("b2b%0d out_addr", i), out_addr, BASE + 32'(4 * (i - 1)));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_output("b2b word_count", 32'(word_count), 32'd3);
    check_output("b2b out_valid",  32'(out_valid),  32'd0);

    // Reset mid-stream clears a held erroneous word without waiting for an edge
    out_ready = 1'b0;
    apply_stimulus(vecs[8]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("pre-rst out_err", 32'(out_err), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("async rst out_valid",  32'(out_valid),  32'd0);
    check_output("async rst out_err",    32'(out_err),    32'd0);
    check_output("async rst out_word",   out_word,        32'd0);
    check_output("async rst out_addr",   out_addr,        BASE);
    check_output("async rst word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("post-rst in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's instruction decode: turns a symbolic instruction (instruction-name enum from risc_v_core_pkg, plus register and immediate fields) into a 32-bit RV32IMA machine word.
- Used by the boot/self-test program builder and the testbench stimulus path to stream encoded words into instruction memory.
- Registered, one-stage pipeline with valid/ready on both sides and a word-address counter for memory writes.

Parameters:
- BASE_ADDR, 32'h0000_0000, first instruction-memory byte address emitted after reset or flush.
- ADDR_W, 32, width of out_addr.

Ports:
- clk  in  1  core clock
- rst  in  1  reset: asynchronous, active-high
- flush  in  1  synchronous; drops the held word and reloads the address counter
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- in_name  in  instr-name enum  operation (package enum, same one the decoder produces)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  signed immediate, byte offset for B/J; U-type uses imm[31:12]
- in_aqrl  in  2  {aq,rl} for atomics, ignored otherwise
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address for out_word
- out_err  out  1  word is INVALID or failed the range check (sticky per word, not across words)
- word_count  out  16  number of words transferred since reset/flush; saturates at 16'hFFFF

Behaviour:
- Reset (async): out_valid=0, out_word=0, out_err=0, out_addr=BASE_ADDR, word_count=0. in_ready goes to 1 after reset deasserts.
- in_ready = !out_valid || out_ready. An accept (in_valid && in_ready) loads the output register on the next edge, so latency is 1 cycle.
- The output transfers when out_valid && out_ready. On a transfer, out_addr += 4 (wrapping modulo 2^ADDR_W) and word_count increments.
- On a transfer with no accept in the same cycle, out_valid drops to 0. A transfer and an accept in the same cycle must give back-to-back words with no bubble.
- While out_valid=1 and out_ready=0, out_word, out_addr and out_err must hold stable.
- flush has priority over everything except rst. Next cycle: out_valid=0, out_addr=BASE_ADDR, word_count=0, and any same-cycle request is dropped.
- Opcodes: R 0110011, LOAD 0000011, OP-IMM 0010011, JALR 1100111, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, AMO 0101111.
- R-type: funct7 is 0000000, except SUB and SRA use 0100000 and the M extension (MUL..REMU, funct3 000..111) uses 0000001.
- I-type: imm[11:0]. SLLI/SRLI use shamt=imm[4:0] with funct7 0; SRAI uses funct7 0100000.
- S-type: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
- B-type: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
- U-type: {imm[31:12],rd,op}.
- J-type: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- AMO: {funct5,aq,rl,rs2,rs1,3'b010,rd,op}. LR_W forces rs2=0. funct5 values: LR 00010, SC 00011, SWAP 00001, ADD 00000, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
- NOP encodes 32'h0000_0013 with out_err=0.
- INVALID, or any enum value not listed above, encodes 32'h0000_0000 with out_err=1.

Optional Feature:
- Macro ENC_IMM_CHECK_EN.
- Defined: out_err is also set when in_imm does not fit the format. Limits: I/S signed 12-bit; B signed 13-bit and even; J signed 21-bit and even; shamt over 31; U with imm[11:0]!=0. The word is still emitted with the truncated fields.
- Undefined: fields are truncated silently and out_err reflects INVALID only.

Test Plan:
- ADDI rd=1 rs1=0 imm=5 -> out_word 0x00500093 one cycle after accept, out_addr=BASE_ADDR, out_err=0.
- Back-to-back ADD 3,1,2 / SUB 3,1,2 / MUL 3,1,2 with out_ready=1 -> 0x002081B3, 0x402081B3, 0x022081B3 on consecutive cycles; addresses +0, +4, +8; word_count=3.
- SW rs2=2 rs1=1 imm=8 -> 0x0020A423. BEQ x0,x0 imm=-4 -> 0xFE000EE3. LUI rd=5 imm=0x12345000 -> 0x123452B7.
- AMOADD rd=3 rs1=1 rs2=2 aqrl=00 -> 0x0020A1AF. INVALID -> 0x00000000 with out_err=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output stable, no address advance. Assert flush mid-stall -> out_valid=0 next cycle, out_addr=BASE_ADDR. Assert rst mid-stream -> all outputs at reset values immediately.
- With ENC_IMM_CHECK_EN: ADDI imm=4096 -> out_err=1 and word 0x00000093. Without the macro -> same word, out_err=0.
